// File: rtl/divide_pkg.sv
// Shared definitions for the iterative restoring divider: state encoding,
// default operand width and the step-counter width helper.
package divide_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/divide_step.sv
// One restoring-division iteration: shift {remainder, dividend} left,
// trial-subtract the divisor and shift the resulting quotient bit in.
module divide_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dvd_next
);

    logic [WIDTH:0] rem_wide;
    logic [WIDTH:0] diff;
    logic           borrow;

    // The partial remainder is always below the divisor, so the shifted value
    // is below twice the divisor and a successful difference fits in WIDTH bits.
    assign rem_wide = {rem, dvd[WIDTH-1]};
    assign diff     = rem_wide - {1'b0, dvs};
    assign borrow   = diff[WIDTH];
    assign rem_next = borrow ? rem_wide[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dvd_next = {dvd[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/divide.sv
// Iterative signed/unsigned integer divider producing one quotient bit per
// clock; handshake is a level-held div_begin and a div_end result flag.
module divide
    import divide_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_begin,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_op1,
    input  logic [WIDTH-1:0] div_op2,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_end
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] rem_reg, dvd_reg, dvs_reg, op1_reg;
    logic             signed_reg, op1_neg_reg, op2_neg_reg, zero_reg;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic             div_end_reg;

    logic             op1_neg, op2_neg;
    logic [WIDTH-1:0] op1_mag, op2_mag;
    logic [WIDTH-1:0] rem_next, dvd_next;
    logic [WIDTH-1:0] q_final, r_final;

    // Magnitudes only for signed operands with the MSB set; 0x80000000 maps to
    // itself, which is correct when read as unsigned.
    assign op1_neg = div_signed & div_op1[WIDTH-1];
    assign op2_neg = div_signed & div_op2[WIDTH-1];
    assign op1_mag = op1_neg ? -div_op1 : div_op1;
    assign op2_mag = op2_neg ? -div_op2 : div_op2;

    divide_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .dvd      (dvd_reg),
        .dvs      (dvs_reg),
        .rem_next (rem_next),
        .dvd_next (dvd_next)
    );

    // Divide by zero overrides the sign fix-up of both results.
    always_comb begin
        q_final = dvd_next;
        r_final = rem_next;
        if (zero_reg) begin
            q_final = '1;
            r_final = op1_reg;
        end else begin
            if (signed_reg && (op1_neg_reg ^ op2_neg_reg)) q_final = -dvd_next;
            if (signed_reg && op1_neg_reg)                 r_final = -rem_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (div_begin) state_next = RUN;
            RUN: begin
                if (!div_begin)              state_next = IDLE;
                else if (cnt_reg == LAST_STEP) state_next = DONE;
            end
            DONE: if (!div_begin) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            rem_reg       <= '0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            op1_reg       <= '0;
            signed_reg    <= 1'b0;
            op1_neg_reg   <= 1'b0;
            op2_neg_reg   <= 1'b0;
            zero_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_end_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (div_begin) begin
                        dvd_reg     <= op1_mag;
                        dvs_reg     <= op2_mag;
                        op1_reg     <= div_op1;
                        signed_reg  <= div_signed;
                        op1_neg_reg <= op1_neg;
                        op2_neg_reg <= op2_neg;
                        zero_reg    <= (div_op2 == '0);
                        rem_reg     <= '0;
                        cnt_reg     <= '0;
                    end
                end
                RUN: begin
                    if (div_begin) begin
                        rem_reg <= rem_next;
                        dvd_reg <= dvd_next;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_STEP) begin
                            quotient_reg  <= q_final;
                            remainder_reg <= r_final;
                            div_end_reg   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!div_begin) div_end_reg <= 1'b0;
                end
                default: div_end_reg <= 1'b0;
            endcase
        end
    end

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign div_end   = div_end_reg;

endmodule

// File: tb/tb_divide.sv
// Scoreboard bench for the iterative divider: directed vectors, abort,
// reset-during-run and a reference-model sweep of back-to-back operations.
module tb_divide;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_begin;
    logic        div_signed;
    logic [31:0] div_op1, div_op2;
    logic [31:0] quotient, remainder;
    logic        div_end;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_r[$];
    logic [31:0] last_q, last_r;
    logic        end_prev = 1'b0;

    always #5 clk = ~clk;

    divide #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_begin  (div_begin),
        .div_signed (div_signed),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_end    (div_end)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    // Monitor: pops one expected result on every rising div_end.
    always @(negedge clk) begin
        if (div_end && !end_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [31:0] eq, er;
                eq = exp_q.pop_front();
                er = exp_r.pop_front();
                chk("quotient", quotient, eq);
                chk("remainder", remainder, er);
                $display("result q=%h r=%h expected q=%h r=%h", quotient, remainder, eq, er);
            end
        end
        end_prev = div_end;
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er);
        int edges;
        @(negedge clk);
        div_op1 = a;
        div_op2 = b;
        div_signed = s;
        div_begin = 1'b1;
        exp_q.push_back(eq);
        exp_r.push_back(er);
        edges = 0;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            // Operands must be ignored once latched.
            if (edges == 5) begin
                div_op1 = $urandom;
                div_op2 = $urandom;
                div_signed = ~s;
            end
            if (div_end) break;
        end
        chk("latency", 32'(edges), 32'd33);
        @(negedge clk);
        div_begin = 1'b0;
        @(posedge clk);
        #1;
        chk("end_fall", {31'd0, div_end}, 32'd0);
        chk("hold_q", quotient, eq);
        chk("hold_r", remainder, er);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        logic [31:0] a, b, q, r;
        logic        s, seen;

        rst = 1'b1;
        div_begin = 1'b0;
        div_signed = 1'b0;
        div_op1 = '0;
        div_op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_end", {31'd0, div_end}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(32'hF000_0000, 32'd2,          1'b0, 32'h7800_0000, 32'd0);
        do_op(32'hF000_0000, 32'd2,          1'b1, 32'hF800_0000, 32'd0);
        do_op(32'd7,         32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD, 32'd1);
        do_op(32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_op(32'd100,       32'd7,          1'b0, 32'd14,        32'd2);
        do_op(32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0);
        do_op(32'h1234_5678, 32'd0,          1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
        do_op(32'hFFFF_FFF9, 32'd0,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        do_op(32'h0000_0005, 32'hFFFF_FFFF,  1'b0, 32'd0,         32'd5);

        // Abort: div_begin low at the 10th edge (a RUN step).
        @(negedge clk);
        div_op1 = 32'd1000;
        div_op2 = 32'd3;
        div_signed = 1'b0;
        div_begin = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        div_begin = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_end) seen = 1'b1;
        end
        chk("abort_end", {31'd0, seen}, 32'd0);
        chk("abort_q", quotient, last_q);
        chk("abort_r", remainder, last_r);

        // Reset at the 20th edge of an operation.
        @(negedge clk);
        div_op1 = 32'd999;
        div_op2 = 32'd4;
        div_begin = 1'b1;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("run_rst_q", quotient, 32'd0);
        chk("run_rst_r", remainder, 32'd0);
        chk("run_rst_end", {31'd0, div_end}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        div_begin = 1'b0;
        @(posedge clk);

        do_op(32'd999, 32'd4, 1'b0, 32'd249, 32'd3);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = (i % 8 == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
            if (i % 4 == 1) b = b >> $urandom_range(0, 31);
            s = i[0];
            ref_div(a, b, s, q, r);
            do_op(a, b, s, q, r);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
